// File: rtl/mem_sig_monitor_if.sv
// Data-bus snoop and dump-stream signals shared by the signature monitor and its driver.
interface mem_sig_monitor_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic              dump_is_fp_o;
    logic [4:0]        dump_idx_o;
    logic [DATA_W-1:0] dump_data_o;

    modport master (
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, dump_ready_i,
        input  dump_valid_o, dump_is_fp_o, dump_idx_o, dump_data_o
    );

    modport slave (
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, dump_ready_i,
        output dump_valid_o, dump_is_fp_o, dump_idx_o, dump_data_o
    );
endinterface

// File: rtl/mem_sig_monitor.sv
// Simulation signature monitor: snoops bus writes for stop/trap/dump, runs RUN/DRAIN/DONE, buffers dumps.
// Define MEM_SIG_MONITOR_FP_DUMP_EN to enable the floating-point dump address and fp_idx counter.
module mem_sig_monitor #(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] ADDR_TRAP  = 'h08,
    parameter logic [ADDR_W-1:0] ADDR_IDUMP = 'h10,
    parameter logic [ADDR_W-1:0] ADDR_FDUMP = 'h18,
    parameter logic [ADDR_W-1:0] ADDR_STOP  = 'h20,
    parameter int unsigned       STOP_DELAY = 50,
    parameter int unsigned       PC_GRACE   = 10,
    parameter int unsigned       CNT_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    mem_sig_monitor_if.slave     bus,
    input  logic [CNT_W-1:0]     simlen_i,
    input  logic                 stop_on_trap_i,
    input  logic                 pc_invalid_i,
    output logic                 running_o,
    output logic                 done_o,
    output logic [2:0]           stop_cause_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [CNT_W-1:0]     trap_cnt_o,
    output logic                 dump_ovf_o
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W  = PTR_W + 1;
    localparam int unsigned ENT_W   = DATA_W + 6;
    localparam int unsigned DRAIN_W = (STOP_DELAY < 1) ? 1 : $clog2(STOP_DELAY + 1);
`ifdef MEM_SIG_MONITOR_FP_DUMP_EN
    localparam logic        FP_EN   = 1'b1;
`else
    localparam logic        FP_EN   = 1'b0;
`endif

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state, w_state_nxt;
    logic [2:0]         r_cause, w_cause_nxt;
    logic [DRAIN_W-1:0] r_drain, w_drain_nxt;
    logic [CNT_W-1:0]   r_cyc, r_trap;
    logic               r_running, r_done, r_ovf;
    logic [4:0]         r_int_idx, w_idx_sel;

    logic w_wr_ev, w_hit_stop, w_hit_trap, w_pc_trig, w_simlen_trig;
    logic w_idump, w_fdump, w_push_req, w_push, w_pop, w_full;

    assign w_wr_ev       = bus.mem_req_i & bus.mem_we_i & (r_state == S_RUN);
    assign w_hit_stop    = w_wr_ev & (bus.mem_addr_i == ADDR_STOP);
    assign w_hit_trap    = w_wr_ev & (bus.mem_addr_i == ADDR_TRAP);
    assign w_idump       = w_wr_ev & (bus.mem_addr_i == ADDR_IDUMP);
    assign w_fdump       = FP_EN & w_wr_ev & (bus.mem_addr_i == ADDR_FDUMP);
    assign w_pc_trig     = pc_invalid_i & (r_cyc >= CNT_W'(PC_GRACE));
    assign w_simlen_trig = (simlen_i != '0) & (r_cyc == simlen_i - CNT_W'(1));

    // Next-state: triggers are only honoured in RUN, highest priority first.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_drain_nxt = r_drain;
        case (r_state)
            S_RUN: begin
                if (w_hit_stop) begin
                    w_state_nxt = S_DRAIN; w_cause_nxt = 3'd1; w_drain_nxt = DRAIN_W'(STOP_DELAY);
                end else if (w_hit_trap && stop_on_trap_i) begin
                    w_state_nxt = S_DRAIN; w_cause_nxt = 3'd2; w_drain_nxt = DRAIN_W'(STOP_DELAY);
                end else if (w_pc_trig) begin
                    w_state_nxt = S_DRAIN; w_cause_nxt = 3'd3; w_drain_nxt = DRAIN_W'(STOP_DELAY);
                end else if (w_simlen_trig) begin
                    w_state_nxt = S_DONE;  w_cause_nxt = 3'd4;
                end
            end
            S_DRAIN: begin
                if (r_drain == '0) w_state_nxt = S_DONE;
                else               w_drain_nxt = r_drain - DRAIN_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_RUN;
            r_cause   <= 3'd0;
            r_drain   <= '0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
            r_drain   <= w_drain_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    // Saturating cycle and trap counters; the cycle counter freezes once DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cyc  <= '0;
            r_trap <= '0;
        end else begin
            if (r_state != S_DONE && r_cyc != '1) r_cyc <= r_cyc + CNT_W'(1);
            if (w_hit_trap && r_trap != '1)      r_trap <= r_trap + CNT_W'(1);
        end
    end

    // Dump indices advance on every accepted dump write, even if the FIFO drops it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_int_idx <= 5'd1;
        else if (w_idump) r_int_idx <= r_int_idx + 5'd1;
    end

`ifdef MEM_SIG_MONITOR_FP_DUMP_EN
    logic [4:0] r_fp_idx;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_fp_idx <= 5'd0;
        else if (w_fdump) r_fp_idx <= r_fp_idx + 5'd1;
    end
    assign w_idx_sel = w_fdump ? r_fp_idx : r_int_idx;
`else
    assign w_idx_sel = r_int_idx;
`endif

    // FWFT FIFO: storage ring plus a registered head copy driving the dump outputs.
    logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd, r_wr, w_rd_nxt;
    logic [FCNT_W-1:0] r_fcnt, w_fcnt_nxt;
    logic              r_dump_valid;
    logic [ENT_W-1:0]  r_dump_ent, w_entry, w_head_nxt;

    assign w_push_req = w_idump | w_fdump;
    assign w_entry    = {w_fdump, w_idx_sel, bus.mem_wdata_i};
    assign w_full     = (r_fcnt == FCNT_W'(FIFO_DEPTH));
    assign w_pop      = r_dump_valid & bus.dump_ready_i;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_rd_nxt   = w_pop ? r_rd + PTR_W'(1) : r_rd;
    assign w_head_nxt = (w_push && r_wr == w_rd_nxt) ? w_entry : r_mem[w_rd_nxt];

    always_comb begin
        w_fcnt_nxt = r_fcnt;
        case ({w_push, w_pop})
            2'b10:   w_fcnt_nxt = r_fcnt + FCNT_W'(1);
            2'b01:   w_fcnt_nxt = r_fcnt - FCNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= w_entry;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd         <= '0;
            r_wr         <= '0;
            r_fcnt       <= '0;
            r_dump_valid <= 1'b0;
            r_dump_ent   <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_rd         <= w_rd_nxt;
            r_fcnt       <= w_fcnt_nxt;
            r_dump_valid <= (w_fcnt_nxt != '0);
            if (w_push)                r_wr       <= r_wr + PTR_W'(1);
            if (w_fcnt_nxt != '0)      r_dump_ent <= w_head_nxt;
            if (w_push_req && !w_push) r_ovf      <= 1'b1;
        end
    end

    assign bus.dump_valid_o = r_dump_valid;
    assign bus.dump_is_fp_o = r_dump_ent[ENT_W-1];
    assign bus.dump_idx_o   = r_dump_ent[DATA_W +: 5];
    assign bus.dump_data_o  = r_dump_ent[DATA_W-1:0];
    assign running_o        = r_running;
    assign done_o           = r_done;
    assign stop_cause_o     = r_cause;
    assign cycle_cnt_o      = r_cyc;
    assign trap_cnt_o       = r_trap;
    assign dump_ovf_o       = r_ovf;
endmodule
